// File: rtl/wave_gen_multi.sv
// Multi-channel square/PWM/burst waveform generator with a word-addressed
// register port: {channel, reg[1:0]} selects CTRL, PERIOD, DUTY or BURST.
module wave_gen_multi #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    localparam int ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] out_wave,
    output logic              irq
);

    logic [ADDR_W-1:0] w_addr_ch;
    logic [31:0]       w_rd [NUM_CH];
    logic [31:0]       w_rd_mux;
    logic [NUM_CH-1:0] w_irq;
    logic [31:0]       r_readdata;
    logic              w_unused;

    assign w_addr_ch = avs_address >> 2;
    // Register fields do not use every data bit.
    assign w_unused  = ^avs_writedata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             r_en;
            logic             r_en_prev;
            logic             r_irq_en;
            logic             r_done;
            logic             r_wave;
            logic [1:0]       r_mode;
            logic [CNT_W-1:0] r_per_sh;
            logic [CNT_W-1:0] r_duty_sh;
            logic [CNT_W-1:0] r_per_act;
            logic [CNT_W-1:0] r_duty_act;
            logic [CNT_W-1:0] r_cnt;
            logic [15:0]      r_burst_n;
            logic [15:0]      r_burst_cnt;

            logic w_sel;
            logic w_wr_ctrl;
            logic w_wr_per;
            logic w_wr_duty;
            logic w_wr_burst;
            logic w_burst_mode;
            logic w_square_mode;
            logic w_wrap;
            logic w_burst_last;

            assign w_sel         = (w_addr_ch == ADDR_W'(gi));
            assign w_wr_ctrl     = avs_write && w_sel && (avs_address[1:0] == 2'd0);
            assign w_wr_per      = avs_write && w_sel && (avs_address[1:0] == 2'd1);
            assign w_wr_duty     = avs_write && w_sel && (avs_address[1:0] == 2'd2);
            assign w_wr_burst    = avs_write && w_sel && (avs_address[1:0] == 2'd3);
            assign w_burst_mode  = (r_mode == 2'b10);
            assign w_square_mode = (r_mode == 2'b00);
            assign w_wrap        = (r_cnt == r_per_act - CNT_W'(1));
            assign w_burst_last  = (({1'b0, r_burst_cnt} + 17'd1) == {1'b0, r_burst_n});

            always_ff @(posedge clk_clk) begin
                if (!reset_reset_n) begin
                    r_en        <= 1'b0;
                    r_en_prev   <= 1'b0;
                    r_irq_en    <= 1'b0;
                    r_done      <= 1'b0;
                    r_wave      <= 1'b0;
                    r_mode      <= 2'b00;
                    r_per_sh    <= '0;
                    r_duty_sh   <= '0;
                    r_per_act   <= '0;
                    r_duty_act  <= '0;
                    r_cnt       <= '0;
                    r_burst_n   <= '0;
                    r_burst_cnt <= '0;
                end else begin
                    // W1C first so a hardware DONE set later in this block wins.
                    if (w_wr_burst && avs_writedata[31]) begin
                        r_done <= 1'b0;
                    end
                    r_en_prev <= r_en;

                    if (!r_en) begin
                        r_cnt      <= '0;
                        r_wave     <= 1'b0;
                        r_per_act  <= r_per_sh;
                        r_duty_act <= r_duty_sh;
                    end else if (!r_en_prev) begin
                        r_cnt       <= '0;
                        r_burst_cnt <= '0;
                        r_wave      <= 1'b0;
                        r_per_act   <= r_per_sh;
                        r_duty_act  <= r_duty_sh;
                        if (w_burst_mode && (r_burst_n == 16'd0)) begin
                            r_done    <= 1'b1;
                            r_en      <= 1'b0;
                            r_en_prev <= 1'b0;
                        end
                    end else if (r_per_act == '0) begin
                        // Zero period never wraps, so keep tracking the shadow.
                        r_cnt      <= '0;
                        r_wave     <= 1'b0;
                        r_per_act  <= r_per_sh;
                        r_duty_act <= r_duty_sh;
                    end else begin
                        r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                        r_wave <= w_square_mode ? (r_wave ^ w_wrap) : (r_cnt < r_duty_act);
                        if (w_wrap) begin
                            r_per_act  <= r_per_sh;
                            r_duty_act <= r_duty_sh;
                            if (w_burst_mode) begin
                                if (w_burst_last) begin
                                    r_done    <= 1'b1;
                                    r_wave    <= 1'b0;
                                    r_en      <= 1'b0;
                                    // Forces a fresh start if software re-enables now.
                                    r_en_prev <= 1'b0;
                                end else begin
                                    r_burst_cnt <= r_burst_cnt + 16'd1;
                                end
                            end
                        end
                    end

                    // Software writes last so a same-cycle EN write beats the burst clear.
                    if (w_wr_ctrl) begin
                        r_en     <= avs_writedata[0];
                        r_mode   <= avs_writedata[2:1];
                        r_irq_en <= avs_writedata[3];
                    end
                    if (w_wr_per) begin
                        r_per_sh <= avs_writedata[CNT_W-1:0];
                    end
                    if (w_wr_duty) begin
                        r_duty_sh <= avs_writedata[CNT_W-1:0];
                    end
                    if (w_wr_burst) begin
                        r_burst_n <= avs_writedata[15:0];
                    end
                end
            end

            assign w_rd[gi] = (avs_address[1:0] == 2'd0) ? {28'd0, r_irq_en, r_mode, r_en} :
                              (avs_address[1:0] == 2'd1) ? 32'(r_per_sh) :
                              (avs_address[1:0] == 2'd2) ? 32'(r_duty_sh) :
                                                           {r_done, 15'd0, r_burst_n};
            assign out_wave[gi] = r_wave;
            assign w_irq[gi]    = r_done & r_irq_en;
        end
    endgenerate

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_addr_ch == ADDR_W'(i)) begin
                w_rd_mux = w_rd[i];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign avs_readdata = r_readdata;
    assign irq          = |w_irq;

endmodule

// File: tb/tb_wave_gen_multi.sv
// Directed bench for wave_gen_multi: register table plus waveform sequences
// compared against hand-derived timing formulas.
module tb_wave_gen_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  addr = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [1:0]  wave;
    logic        irq;

    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned cyc = 0;

    typedef struct {
        bit          do_wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl [10];

    wave_gen_multi #(.NUM_CH(2), .CNT_W(16)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs_address   (addr),
        .avs_write     (wr),
        .avs_writedata (wdata),
        .avs_read      (rd),
        .avs_readdata  (rdata),
        .out_wave      (wave),
        .irq           (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = 0x%0h", name, got);
        end else begin
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Write edge is the posedge between the two negedges; on return cyc equals it.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    // i = clock edges since the EN write edge; first edge restarts, second shows counter 0.
    function automatic bit pwm_exp(int i, int p, int d);
        if (i < 2 || p == 0) return 1'b0;
        return ((i - 2) % p) < d;
    endfunction

    function automatic bit sq_exp(int i, int p);
        if (i < 1 || p == 0) return 1'b0;
        return (((i - 1) / p) % 2) == 1;
    endfunction

    task automatic run_pwm(input int p, input int d, input int n, input string name);
        logic [63:0] got, exp;
        int unsigned t;
        bus_write(3'd0, 32'd0);
        bus_write(3'd1, 32'(p));
        bus_write(3'd2, 32'(d));
        bus_write(3'd0, 32'h3);
        t = cyc; got = '0; exp = '0;
        for (int k = 0; k < n; k++) begin
            got[k] = wave[0];
            exp[k] = pwm_exp(int'(cyc - t), p, d);
            @(negedge clk);
        end
        check(name, got, exp);
    endtask

    initial begin
        logic [31:0] v;
        logic [63:0] g0, e0, g1, e1;
        int unsigned t0, t1, t, w;
        int          i, pw, kk;

        tbl[0] = '{1'b1, 3'd1, 32'h0001_2345, 32'h0000_2345};
        tbl[1] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_FFFF};
        tbl[2] = '{1'b1, 3'd3, 32'h8001_0005, 32'h0000_0005};
        tbl[3] = '{1'b1, 3'd0, 32'hFFFF_FFF6, 32'h0000_0006};
        tbl[4] = '{1'b1, 3'd5, 32'h0000_0004, 32'h0000_0004};
        tbl[5] = '{1'b1, 3'd6, 32'h0000_ABCD, 32'h0000_ABCD};
        tbl[6] = '{1'b1, 3'd7, 32'h7FFF_0010, 32'h0000_0010};
        tbl[7] = '{1'b1, 3'd4, 32'h0000_000A, 32'h0000_000A};
        tbl[8] = '{1'b0, 3'd1, 32'h0,         32'h0000_2345};
        tbl[9] = '{1'b0, 3'd2, 32'h0,         32'h0000_FFFF};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_wave", 64'(wave), 64'd0);
        check("reset_irq", 64'(irq), 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), v);
            check($sformatf("reset_reg%0d", a), 64'(v), 64'd0);
        end

        // Register table: write then read back (or read only)
        for (int k = 0; k < 10; k++) begin
            if (tbl[k].do_wr) bus_write(tbl[k].a, tbl[k].d);
            bus_read(tbl[k].a, v);
            check($sformatf("reg_tbl%0d_a%0d", k, tbl[k].a), 64'(v), 64'(tbl[k].exp));
        end
        bus_write(3'd0, 32'd0);
        bus_write(3'd4, 32'd0);

        // ch0 PWM period 10 duty 3
        bus_write(3'd1, 32'd10);
        bus_write(3'd2, 32'd3);
        bus_write(3'd0, 32'h3);
        t0 = cyc; g0 = '0; e0 = '0;
        for (int k = 0; k < 20; k++) begin
            g0[k] = wave[0];
            e0[k] = pwm_exp(int'(cyc - t0), 10, 3);
            @(negedge clk);
        end
        check("ch0_pwm_p10_d3", g0, e0);

        // ch1 square period 4 while ch0 keeps running
        bus_write(3'd5, 32'd4);
        bus_write(3'd4, 32'h1);
        t1 = cyc; g0 = '0; e0 = '0; g1 = '0; e1 = '0;
        for (int k = 0; k < 40; k++) begin
            g0[k] = wave[0];
            e0[k] = pwm_exp(int'(cyc - t0), 10, 3);
            g1[k] = wave[1];
            e1[k] = sq_exp(int'(cyc - t1), 4);
            @(negedge clk);
        end
        check("ch1_square_p4", g1, e1);
        check("ch0_undisturbed", g0, e0);

        // Mid-period DUTY change takes effect from the next period
        for (int k = 0; k < 20 && ((int'(cyc - t0) - 2) % 10) != 3; k++) @(negedge clk);
        bus_write(3'd2, 32'd8);
        w = cyc;
        pw = (int'(w - t0) - 2) / 10;
        g0 = '0; e0 = '0;
        for (int k = 0; k < 30; k++) begin
            i = int'(cyc - t0);
            g0[k] = wave[0];
            e0[k] = (((i - 2) / 10) > pw) ? pwm_exp(i, 10, 8) : pwm_exp(i, 10, 3);
            @(negedge clk);
        end
        check("duty_shadow_update", g0, e0);

        bus_write(3'd0, 32'd0);
        bus_write(3'd4, 32'd0);
        @(negedge clk);
        check("disabled_low", 64'(wave), 64'd0);

        run_pwm(10, 0, 24, "duty0_low");
        run_pwm(10, 12, 24, "duty12_high");
        run_pwm(0, 3, 16, "period0_low");

        // Burst N=3, period 5, duty 2, IRQ enabled
        bus_write(3'd0, 32'd0);
        bus_write(3'd1, 32'd5);
        bus_write(3'd2, 32'd2);
        bus_write(3'd3, 32'd3);
        bus_write(3'd0, 32'd13);
        t = cyc; g0 = '0; e0 = '0; g1 = '0; e1 = '0;
        for (int k = 0; k < 24; k++) begin
            i = int'(cyc - t);
            kk = i - 2;
            g0[k] = wave[0];
            e0[k] = (i >= 2) && (kk < 15) && ((kk % 5) < 2);
            g1[k] = irq;
            e1[k] = (i >= 16);
            @(negedge clk);
        end
        check("burst3_wave", g0, e0);
        check("burst3_irq", g1, e1);
        bus_read(3'd0, v);
        check("burst3_ctrl", 64'(v), 64'hC);
        bus_read(3'd3, v);
        check("burst3_status", 64'(v), 64'h8000_0003);
        bus_write(3'd3, 32'h8000_0003);
        @(negedge clk);
        check("w1c_irq", 64'(irq), 64'd0);
        bus_read(3'd3, v);
        check("w1c_status", 64'(v), 64'h3);

        // Burst N=0 completes right after the EN write
        bus_write(3'd3, 32'h8000_0000);
        bus_write(3'd0, 32'd13);
        t = cyc; g0 = '0; g1 = '0; e1 = '0;
        for (int k = 0; k < 6; k++) begin
            g0[k] = wave[0];
            g1[k] = irq;
            e1[k] = (int'(cyc - t) >= 1);
            @(negedge clk);
        end
        check("burst0_wave", g0, 64'd0);
        check("burst0_irq", g1, e1);
        bus_read(3'd0, v);
        check("burst0_ctrl", 64'(v), 64'hC);

        // Burst N=1: EN rewritten on the completion edge restarts the burst
        bus_write(3'd3, 32'h8000_0001);
        bus_write(3'd0, 32'd13);
        t = cyc;
        for (int k = 0; k < 10 && cyc != t + 4; k++) @(negedge clk);
        bus_write(3'd0, 32'd13);
        check("restart_edge", 64'(cyc - t), 64'd6);
        t = cyc; g0 = '0; e0 = '0;
        for (int k = 0; k < 14; k++) begin
            i = int'(cyc - t);
            g0[k] = wave[0];
            e0[k] = (i == 2) || (i == 3);
            @(negedge clk);
        end
        check("restart_wave", g0, e0);
        bus_read(3'd3, v);
        check("restart_status", 64'(v), 64'h8000_0001);

        // Reset in the middle of a burst aborts it
        bus_write(3'd3, 32'h8000_0003);
        bus_write(3'd0, 32'd13);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_wave", 64'(wave), 64'd0);
        check("abort_irq", 64'(irq), 64'd0);
        check("abort_rdata", 64'(rdata), 64'd0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), v);
            check($sformatf("abort_reg%0d", a), 64'(v), 64'd0);
        end
        g0 = '0; g1 = '0;
        for (int k = 0; k < 25; k++) begin
            g0[k] = wave[0];
            g1[k] = irq;
            @(negedge clk);
        end
        check("abort_wave_hold", g0, 64'd0);
        check("abort_irq_hold", g1, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
